// File: rtl/axi_pkg.sv
// axi_pkg: burst/response encodings and request/beat records for the AXI ROM slave
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] BURST_RSVD = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic {IDLE, BURST} state_t;
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_req_t;
  typedef struct packed {
    logic [3:0] id;
    logic [31:0] data;
    logic [1:0] resp;
    logic last;
  } r_beat_t;
endpackage

// File: rtl/axi_rom_slave_if.sv
// axi_rom_slave_if: AXI read address and read data channels
interface axi_rom_slave_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport slave(
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master(
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with power-of-2 depth and async active-low reset
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic empty,
  output logic [$clog2(D):0] count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  // pointers and occupancy; callers never push when full nor pop when empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage is never read before it is written, so it carries no reset
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/axi_rom_slave.sv
// axi_rom_slave: AXI read responder over a 1-cycle-latency ROM; define AXI_ROM_WRAP_EN to support WRAP bursts
module axi_rom_slave
  import axi_pkg::*;
#(
  parameter int AR_DEPTH = 4,
  parameter int MEM_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h1C000000
) (
  input  logic aclk,
  input  logic aresetn,
  axi_rom_slave_if.slave bus,
  output logic mem_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  input  logic [31:0] mem_rdata
);
  localparam int MAW = $clog2(MEM_WORDS);
  localparam int AAW = $clog2(AR_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  state_t state;
  ar_req_t ar_in, head, cur_q, cur;
  logic ar_push, ar_pop, ar_empty, arready_q;
  logic [AAW:0] ar_cnt, ar_nxt;
  logic [7:0] beat_q, beat;
  logic p_valid, p_mem, p_last;
  logic [3:0] p_id;
  logic [1:0] p_resp, resp, ob_cnt;
  r_beat_t ob_in, ob_out, r_out;
  logic ob_empty, ob_pop, active, issue, fin, slv, wrap_bad, in_rng;
  logic [31:0] off, step, al, wrap_addr, nxt_addr;
  assign ar_in = '{id: bus.arid, addr: bus.araddr, len: bus.arlen, size: bus.arsize, burst: bus.arburst};
  assign ar_push = bus.arvalid & arready_q;
  assign ar_nxt = ar_cnt + (AAW+1)'(ar_push) - (AAW+1)'(ar_pop);
  assign bus.arready = arready_q;
  sync_fifo #(.W($bits(ar_req_t)), .D(AR_DEPTH)) u_ar (
    .clk(aclk), .rst_n(aresetn), .push(ar_push), .din(ar_in), .pop(ar_pop),
    .dout(head), .empty(ar_empty), .count(ar_cnt)
  );
  // In IDLE the queue head is served directly, so its first beat issues in the pop cycle.
  assign cur = state == BURST ? cur_q : head;
  assign beat = state == BURST ? beat_q : '0;
  assign active = state == BURST | !ar_empty;
  assign ob_pop = !ob_empty & bus.rready;
  assign issue = active & ((ob_cnt + 2'(p_valid) - 2'(ob_pop)) < 2'd2);
  assign ar_pop = issue & state == IDLE;
  assign fin = beat == cur.len;
  assign step = 32'd1 << cur.size;
  assign al = cur.addr & ~(step - 32'd1);
`ifdef AXI_ROM_WRAP_EN
  logic [31:0] bnd;
  assign bnd = (32'(cur.len) + 32'd1) << cur.size;
  assign wrap_bad = cur.burst == BURST_WRAP & !(cur.len inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign wrap_addr = (al & ~(bnd - 32'd1)) | ((al + step) & (bnd - 32'd1));
`else
  assign wrap_bad = cur.burst == BURST_WRAP;
  assign wrap_addr = al + step;
`endif
  assign nxt_addr = cur.burst == BURST_FIXED ? cur.addr : cur.burst == BURST_INCR ? al + step : wrap_addr;
  assign slv = cur.size > 3'd2 | cur.burst == BURST_RSVD | wrap_bad;
  assign off = cur.addr - BASE_ADDR;
  assign in_rng = off < MEM_BYTES;
  assign resp = slv ? RESP_SLVERR : in_rng ? RESP_OKAY : RESP_DECERR;
  assign mem_en = issue & resp == RESP_OKAY;
  assign mem_addr = mem_en ? off[MAW+1:2] : '0;
  // burst sequencer and the one-deep memory-latency stage feeding the output buffer
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      cur_q <= '0;
      beat_q <= '0;
      p_valid <= 1'b0;
      p_mem <= 1'b0;
      p_last <= 1'b0;
      p_id <= '0;
      p_resp <= '0;
      arready_q <= 1'b0;
    end else begin
      arready_q <= ar_nxt != (AAW+1)'(AR_DEPTH);
      p_valid <= issue;
      p_mem <= mem_en;
      p_last <= fin;
      p_id <= cur.id;
      p_resp <= resp;
      if (issue) begin
        state <= fin ? IDLE : BURST;
        cur_q <= cur;
        cur_q.addr <= nxt_addr;
        beat_q <= beat + 8'd1;
      end
    end
  assign ob_in = '{id: p_id, data: p_mem ? mem_rdata : 32'd0, resp: p_resp, last: p_last};
  sync_fifo #(.W($bits(r_beat_t)), .D(2)) u_ob (
    .clk(aclk), .rst_n(aresetn), .push(p_valid), .din(ob_in), .pop(ob_pop),
    .dout(ob_out), .empty(ob_empty), .count(ob_cnt)
  );
  assign r_out = ob_empty ? '0 : ob_out;
  assign bus.rvalid = !ob_empty;
  assign bus.rid = r_out.id;
  assign bus.rdata = r_out.data;
  assign bus.rresp = r_out.resp;
  assign bus.rlast = r_out.last;
endmodule
